cache_control_nway: RTL and testbench

- Parametrised successor to the two-way cache controller.
- Drives an N-way set-associative, write-back, write-allocate cache datapath: tag/valid/dirty/data array load strobes, datapath muxes, and the physical-memory handshake.
- Holds a per-set tree pseudo-LRU internally and selects the victim way itself.
- Sits between the CPU-side memory port and the cacheline adaptor.

---
 rtl/cache_control_nway.sv | 254 +++++++++++++++++++++++++
 tb/tb_cache_control_nway.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_nway.sv
// cache_control_nway
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// It keeps a tree pseudo-LRU per set and chooses the victim way itself.
// It drives the array load strobes, the datapath muxes and the physical-memory
// handshake toward the cacheline adaptor.
// Optional build macro: PERF_CNT_EN adds saturating hit/miss/writeback counters
// and their output ports. Without the macro the counters and ports are absent.
module cache_control_nway #(
    parameter int NUM_WAYS = 4,
    parameter int S_INDEX  = 4,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // CPU-side request port
    input  logic                        mem_read,
    input  logic                        mem_write,
    output logic                        mem_resp,
    input  logic [S_INDEX-1:0]          set_index,
    // Status of the indexed set, from the datapath
    input  logic [NUM_WAYS-1:0]         hit_vec,
    input  logic [NUM_WAYS-1:0]         valid_vec,
    input  logic [NUM_WAYS-1:0]         dirty_vec,
    // Cacheline adaptor handshake
    output logic                        pmem_read,
    output logic                        pmem_write,
    input  logic                        pmem_resp,
    // Array write enables, one-hot per way
    output logic [NUM_WAYS-1:0]         load_tag,
    output logic [NUM_WAYS-1:0]         load_valid,
    output logic [NUM_WAYS-1:0]         load_dirty,
    output logic [NUM_WAYS-1:0]         load_data,
    // Datapath controls
    output logic                        dirty_in,
    output logic                        data_sel,
    output logic                        addr_sel,
    output logic [$clog2(NUM_WAYS)-1:0] way_sel
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt,
    output logic [CNT_W-1:0]            wb_cnt
`endif
);

    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int NUM_SETS = 2 ** S_INDEX;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MATCH = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_FILL  = 3'd4;

    localparam logic [NUM_WAYS-1:0] WAY0_ONEHOT = NUM_WAYS'(1);

    // Supported configurations: power-of-two associativity 2..8 and a non-empty
    // counter width. This block stays empty for a legal configuration.
    if (NUM_WAYS < 2 || NUM_WAYS > 8 || (NUM_WAYS & (NUM_WAYS - 1)) != 0 || CNT_W < 1)
    begin : g_unsupported_configuration
    end

    logic [2:0]          state_q, state_d;
    logic [WAY_W-1:0]    victim_q, victim_d;

    // Tree bits per set. The tree has NUM_WAYS-1 nodes in heap order:
    // node n has children 2n+1 (left, lower ways) and 2n+2 (right).
    // The storage is NUM_WAYS wide, so a WAY_W-bit node index always fits.
    // The top bit is never a tree node and stays 0.
    logic [NUM_WAYS-1:0] plru_q [NUM_SETS];
    logic [NUM_WAYS-1:0] plru_cur;
    logic [NUM_WAYS-1:0] plru_upd;
    logic                plru_we;

    logic                hit_any;
    logic                inv_any;
    logic                victim_dirty;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_way;
    logic [WAY_W-1:0]    miss_way;

    assign hit_any  = |hit_vec;
    assign inv_any  = ~&valid_vec;
    assign plru_cur = plru_q[set_index];

    // A multi-hot hit vector resolves to its lowest set bit.
    always_comb begin
        hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAY_W'(i);
            end
        end
    end

    // An invalid way is always preferred as the victim. Pick the lowest-index one.
    always_comb begin
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                inv_way = WAY_W'(i);
            end
        end
    end

    // Walk the tree from the root to find the PLRU victim. A 0 bit goes left.
    // Each level yields one way-index bit, MSB first.
    always_comb begin
        logic [WAY_W-1:0] node;
        node     = '0;
        plru_way = '0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            plru_way[lvl] = plru_cur[node];
            node = WAY_W'(2 * int'(node) + 1 + int'(plru_cur[node]));
        end
    end

    // Along the path to the hit way, set every node to point to the other subtree.
    always_comb begin
        logic [WAY_W-1:0] node;
        node     = '0;
        plru_upd = plru_cur;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            plru_upd[node] = ~hit_way[lvl];
            node = WAY_W'(2 * int'(node) + 1 + int'(hit_way[lvl]));
        end
    end

    assign miss_way     = inv_any ? inv_way : plru_way;
    assign victim_dirty = valid_vec[miss_way] & dirty_vec[miss_way];

    // Next-state logic and decode of all outputs from the current state.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        plru_we    = 1'b0;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_tag   = '0;
        load_valid = '0;
        load_dirty = '0;
        load_data  = '0;
        dirty_in   = 1'b0;
        data_sel   = 1'b0;
        addr_sel   = 1'b0;
        way_sel    = '0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = ST_MATCH;
                end
            end
            ST_MATCH: begin
                way_sel = hit_way;
                if (hit_any) begin
                    mem_resp = 1'b1;
                    plru_we  = 1'b1;
                    // A write request wins when both request bits are set.
                    if (mem_write) begin
                        load_data  = WAY0_ONEHOT << hit_way;
                        load_dirty = WAY0_ONEHOT << hit_way;
                        dirty_in   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    victim_d = miss_way;
                    state_d  = victim_dirty ? ST_WB : ST_FILL;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_WB: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = victim_q;
                if (pmem_resp) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                pmem_read  = 1'b1;
                data_sel   = 1'b1;
                way_sel    = victim_q;
                // Tag, valid and the clean dirty bit are rewritten every fill cycle.
                // Only the final write of those values matters.
                load_tag   = WAY0_ONEHOT << victim_q;
                load_valid = WAY0_ONEHOT << victim_q;
                load_dirty = WAY0_ONEHOT << victim_q;
                if (pmem_resp) begin
                    load_data = WAY0_ONEHOT << victim_q;
                    state_d   = ST_MATCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched victim way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Per-set PLRU storage. Every hit updates the tree of its set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (plru_we) begin
            plru_q[set_index] <= plru_upd;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] wb_cnt_q;

    // Saturating event counters: MATCH hit, MATCH miss, and WRITEBACK completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == ST_MATCH && hit_any && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (state_q == ST_MATCH && !hit_any && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (state_q == ST_WB && pmem_resp && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// tb_cache_control_nway
// Applies a table of cycle-by-cycle vectors to cache_control_nway (4 ways, 16 sets).
// The expected outputs travel through a scoreboard queue. Hand-written sequences
// then cover an asynchronous reset in the middle of FILL and the PLRU clear it causes.
// Define PERF_CNT_EN for both the bench and the RTL to also check the counters.
module tb_cache_control_nway;
    localparam int NW = 4;
    localparam int SI = 4;
    localparam int CW = 32;

    localparam logic       N  = 1'b0;
    localparam logic       Y  = 1'b1;
    localparam logic [3:0] Z4 = 4'h0;
    localparam logic [3:0] F4 = 4'hF;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [3:0] set;
        logic [3:0] hit;
        logic [3:0] valid;
        logic [3:0] dirty;
        logic       presp;
        logic       e_resp;
        logic       e_pr;
        logic       e_pw;
        logic [3:0] e_tv;    // expected load_tag and load_valid
        logic [3:0] e_dty;   // expected load_dirty
        logic [3:0] e_data;  // expected load_data
        logic       e_din;
        logic       e_dsel;
        logic       e_asel;
        logic [1:0] e_way;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write, mem_resp;
    logic [SI-1:0] set_index;
    logic [NW-1:0] hit_vec, valid_vec, dirty_vec;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [NW-1:0] load_tag, load_valid, load_dirty, load_data;
    logic          dirty_in, data_sel, addr_sel;
    logic [1:0]    way_sel;
`ifdef PERF_CNT_EN
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int row_no = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(NW), .S_INDEX(SI), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .set_index  (set_index),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .dirty_vec  (dirty_vec),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .load_data  (load_data),
        .dirty_in   (dirty_in),
        .data_sel   (data_sel),
        .addr_sel   (addr_sel),
        .way_sel    (way_sel)
`ifdef PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
`endif
    );

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] set,
                                input logic [3:0] hit, input logic [3:0] valid,
                                input logic [3:0] dirty, input logic presp,
                                input logic resp, input logic pr, input logic pw,
                                input logic [3:0] tv, input logic [3:0] dty,
                                input logic [3:0] data, input logic din,
                                input logic dsel, input logic asel, input logic [1:0] way);
        vec_t v;
        v.rd = rd; v.wr = wr; v.set = set; v.hit = hit; v.valid = valid;
        v.dirty = dirty; v.presp = presp;
        v.e_resp = resp; v.e_pr = pr; v.e_pw = pw; v.e_tv = tv; v.e_dty = dty;
        v.e_data = data; v.e_din = din; v.e_dsel = dsel; v.e_asel = asel; v.e_way = way;
        return v;
    endfunction

    // Row in which every DUT output is expected to be zero.
    function automatic vec_t quiet(input logic rd, input logic wr, input logic [3:0] set,
                                   input logic [3:0] hit, input logic [3:0] valid,
                                   input logic [3:0] dirty, input logic presp);
        return mk(rd, wr, set, hit, valid, dirty, presp, N, N, N, Z4, Z4, Z4, N, N, N, 2'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, 32'({mem_resp, pmem_read, pmem_write, load_tag, load_valid, load_dirty,
                       load_data, dirty_in, data_sel, addr_sel, way_sel}), 32'd0);
    endtask

    task automatic chk_perf(input string name, input int h, input int m, input int w);
`ifdef PERF_CNT_EN
        chk({name, ".hit_cnt"},  hit_cnt,  32'(h));
        chk({name, ".miss_cnt"}, miss_cnt, 32'(m));
        chk({name, ".wb_cnt"},   wb_cnt,   32'(w));
`else
        if (h < 0 || m < 0 || w < 0) $display("perf %s: negative count request", name);
`endif
    endtask

    task automatic drive(input vec_t v);
        mem_read  = v.rd;
        mem_write = v.wr;
        set_index = v.set;
        hit_vec   = v.hit;
        valid_vec = v.valid;
        dirty_vec = v.dirty;
        pmem_resp = v.presp;
        sb.push_back(v);
    endtask

    task automatic compare();
        vec_t  e;
        string t;
        t = $sformatf("r%0d", row_no);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: actual=empty expected=entry", t);
        end else begin
            e = sb.pop_front();
            chk({t, ".mem_resp"},   32'(mem_resp),   32'(e.e_resp));
            chk({t, ".pmem_read"},  32'(pmem_read),  32'(e.e_pr));
            chk({t, ".pmem_write"}, 32'(pmem_write), 32'(e.e_pw));
            chk({t, ".load_tag"},   32'(load_tag),   32'(e.e_tv));
            chk({t, ".load_valid"}, 32'(load_valid), 32'(e.e_tv));
            chk({t, ".load_dirty"}, 32'(load_dirty), 32'(e.e_dty));
            chk({t, ".load_data"},  32'(load_data),  32'(e.e_data));
            chk({t, ".dirty_in"},   32'(dirty_in),   32'(e.e_din));
            chk({t, ".data_sel"},   32'(data_sel),   32'(e.e_dsel));
            chk({t, ".addr_sel"},   32'(addr_sel),   32'(e.e_asel));
            chk({t, ".way_sel"},    32'(way_sel),    32'(e.e_way));
            chk({t, ".pmem_excl"},  32'(pmem_read & pmem_write), 32'd0);
            $display("row %0d: rd=%0b wr=%0b set=%0d hit=%b presp=%0b -> resp=%0b pr=%0b pw=%0b tag=%b dty=%b data=%b way=%0d",
                     row_no, e.rd, e.wr, e.set, e.hit, e.presp, mem_resp, pmem_read,
                     pmem_write, load_tag, load_dirty, load_data, way_sel);
        end
        row_no++;
    endtask

    task automatic cycle(input vec_t v);
        drive(v);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        vec_t rr;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; set_index = '0;
        hit_vec = '0; valid_vec = '0; dirty_vec = '0; pmem_resp = 1'b0;

        // Read hit on way 2 of set 3.
        tbl.push_back(quiet(Y, N, 4'd3, 4'b0100, F4, Z4, N));
        tbl.push_back(mk(Y, N, 4'd3, 4'b0100, F4, Z4, N, Y, N, N, Z4, Z4, Z4, N, N, N, 2'd2));
        tbl.push_back(quiet(N, N, 4'd3, Z4, F4, Z4, N));
        // Write hit on way 1 of set 0.
        tbl.push_back(quiet(N, Y, 4'd0, 4'b0010, F4, Z4, N));
        tbl.push_back(mk(N, Y, 4'd0, 4'b0010, F4, Z4, N, Y, N, N, Z4, 4'b0010, 4'b0010, Y, N, N, 2'd1));
        tbl.push_back(quiet(N, N, 4'd0, Z4, F4, Z4, N));
        // Miss in set 0 with way 2 invalid: fill way 2 with no writeback.
        tbl.push_back(quiet(Y, N, 4'd0, Z4, 4'b1011, Z4, N));
        tbl.push_back(quiet(Y, N, 4'd0, Z4, 4'b1011, Z4, N));
        tbl.push_back(mk(Y, N, 4'd0, Z4, 4'b1011, Z4, N, N, Y, N, 4'b0100, 4'b0100, Z4, N, Y, N, 2'd2));
        tbl.push_back(mk(Y, N, 4'd0, Z4, 4'b1011, Z4, Y, N, Y, N, 4'b0100, 4'b0100, 4'b0100, N, Y, N, 2'd2));
        tbl.push_back(mk(Y, N, 4'd0, 4'b0100, F4, Z4, N, Y, N, N, Z4, Z4, Z4, N, N, N, 2'd2));
        tbl.push_back(quiet(N, N, 4'd0, Z4, F4, Z4, N));
        // Miss in untouched set 5, all valid, way 0 dirty: writeback then fill of way 0.
        tbl.push_back(quiet(Y, N, 4'd5, Z4, F4, 4'b0001, N));
        tbl.push_back(quiet(Y, N, 4'd5, Z4, F4, 4'b0001, N));
        tbl.push_back(mk(Y, N, 4'd5, Z4, F4, 4'b0001, N, N, N, Y, Z4, Z4, Z4, N, N, Y, 2'd0));
        tbl.push_back(mk(Y, N, 4'd5, Z4, F4, 4'b0001, Y, N, N, Y, Z4, Z4, Z4, N, N, Y, 2'd0));
        tbl.push_back(mk(Y, N, 4'd5, Z4, F4, 4'b0001, N, N, Y, N, 4'b0001, 4'b0001, Z4, N, Y, N, 2'd0));
        tbl.push_back(mk(Y, N, 4'd5, Z4, F4, 4'b0001, Y, N, Y, N, 4'b0001, 4'b0001, 4'b0001, N, Y, N, 2'd0));
        tbl.push_back(mk(Y, N, 4'd5, 4'b0001, F4, Z4, N, Y, N, N, Z4, Z4, Z4, N, N, N, 2'd0));
        tbl.push_back(quiet(N, N, 4'd5, Z4, F4, Z4, N));
        // Clean miss in set 3: after the way-2 hit the PLRU victim is way 0.
        tbl.push_back(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        tbl.push_back(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        tbl.push_back(mk(Y, N, 4'd3, Z4, F4, Z4, Y, N, Y, N, 4'b0001, 4'b0001, 4'b0001, N, Y, N, 2'd0));
        tbl.push_back(mk(Y, N, 4'd3, 4'b0001, F4, Z4, N, Y, N, N, Z4, Z4, Z4, N, N, N, 2'd0));
        tbl.push_back(quiet(N, N, 4'd3, Z4, F4, Z4, N));
        // Read and write together with a multi-hot hit: handled as a write to way 1.
        tbl.push_back(quiet(Y, Y, 4'd7, 4'b0110, F4, Z4, N));
        tbl.push_back(mk(Y, Y, 4'd7, 4'b0110, F4, Z4, N, Y, N, N, Z4, 4'b0010, 4'b0010, Y, N, N, 2'd1));
        tbl.push_back(quiet(N, N, 4'd7, Z4, F4, Z4, N));

        repeat (2) @(negedge clk);
        chk_quiet("reset.outputs");
        chk_perf("reset", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) cycle(tbl[i]);
        chk_perf("after_table", 6, 3, 1);

        // Set 3 now points at way 3. Enter FILL, then reset between clock edges.
        cycle(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        cycle(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        rr = mk(Y, N, 4'd3, Z4, F4, Z4, N, N, Y, N, 4'b1000, 4'b1000, Z4, N, Y, N, 2'd3);
        drive(rr);
        @(negedge clk);
        compare();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.pmem_read", 32'(pmem_read), 32'd0);
        chk_quiet("async_rst.outputs");
        mem_read = 1'b0;
        @(negedge clk);
        chk_quiet("reset_hold.outputs");
        chk_perf("reset_hold", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // The PLRU was cleared, so the same clean miss now fills way 0.
        cycle(quiet(N, N, 4'd3, Z4, F4, Z4, N));
        cycle(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        cycle(quiet(Y, N, 4'd3, Z4, F4, Z4, N));
        cycle(mk(Y, N, 4'd3, Z4, F4, Z4, Y, N, Y, N, 4'b0001, 4'b0001, 4'b0001, N, Y, N, 2'd0));
        cycle(mk(Y, N, 4'd3, 4'b0001, F4, Z4, N, Y, N, N, Z4, Z4, Z4, N, N, N, 2'd0));
        cycle(quiet(N, N, 4'd3, Z4, F4, Z4, N));
        chk_perf("after_reset_seq", 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
